// File: rtl/ahb_top.sv
// AHB-to-APB subsystem: request capture, SETUP/ACCESS bridge FSM, APB register file.
// Optional herror output for out-of-range transfers under AHB_TOP_ERR_EN.
module ahb_top #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 32
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hwrite,
    input  logic [DATA_W-1:0] addr,
    input  logic              hreadyout,
    input  logic [DATA_W-1:0] data,
    input  logic [2:0]        hburst,
    input  logic [2:0]        hsize,
    output logic [DATA_W-1:0] read_data,
`ifdef AHB_TOP_ERR_EN
    output logic              herror,
`endif
    output logic              hready
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;
    logic              cap_write;
    logic [DATA_W-1:0] masked;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              psel;
    logic              penable;
    logic              capture;
    logic              commit;
    logic              in_range;
    logic              unused_burst;

    assign unused_burst = ^hburst;

    // Size masking is applied at capture, so the bridge only sees final data
    always_comb begin
        masked = data;
        case (hsize)
            3'd0:    masked = {{(DATA_W-8){1'b0}}, data[7:0]};
            3'd1:    masked = {{(DATA_W-16){1'b0}}, data[15:0]};
            default: masked = data;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        psel     = 1'b0;
        penable  = 1'b0;
        hready   = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                hready = 1'b1;
                if (hreadyout) begin
                    capture  = 1'b1;
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                psel     = 1'b1;
                state_nx = ACCESS;
            end
            ACCESS: begin
                psel     = 1'b1;
                penable  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // pready is always 1, so every ACCESS cycle completes
    assign commit   = psel & penable;
    assign in_range = (cap_addr >> IDX_W) == '0;
    assign idx      = cap_addr[IDX_W-1:0];

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            cap_addr  <= '0;
            cap_data  <= '0;
            cap_write <= 1'b0;
        end else if (capture) begin
            cap_addr  <= addr;
            cap_data  <= masked;
            cap_write <= hwrite;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (commit && cap_write && in_range) begin
            mem[idx] <= cap_data;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)
            read_data <= '0;
        else if (commit && !cap_write)
            read_data <= in_range ? mem[idx] : '0;
    end

`ifdef AHB_TOP_ERR_EN
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) herror <= 1'b0;
        else          herror <= commit & ~in_range;
    end
`endif

endmodule

// File: tb/tb_ahb_top.sv
// Randomized scoreboard bench for ahb_top: transaction-level model predicts
// acceptance, stored words and read results; a monitor checks each completion.
module tb_ahb_top;

    localparam int DEPTH = 32;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hwrite;
    logic [31:0] addr;
    logic        hreadyout;
    logic [31:0] data;
    logic [2:0]  hburst;
    logic [2:0]  hsize;
    logic [31:0] read_data;
    logic        hready;
`ifdef AHB_TOP_ERR_EN
    logic        herror;
`endif

    ahb_top #(.DEPTH(DEPTH), .DATA_W(32)) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hwrite    (hwrite),
        .addr      (addr),
        .hreadyout (hreadyout),
        .data      (data),
        .hburst    (hburst),
        .hsize     (hsize),
        .read_data (read_data),
`ifdef AHB_TOP_ERR_EN
        .herror    (herror),
`endif
        .hready    (hready)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic        rd;
        logic [31:0] val;
        logic        oor;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] shadow [DEPTH];
    logic [31:0] last_rd;
    int          busy;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        last_rd = '0;
        busy    = 0;
        sbq.delete();
    endtask

    function automatic logic [31:0] size_mask(input logic [31:0] d,
                                              input logic [2:0] s);
        if (s == 3'd0) return d & 32'h0000_00FF;
        if (s == 3'd1) return d & 32'h0000_FFFF;
        return d;
    endfunction

    task automatic accept(input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] s);
        exp_t e;
        logic oor;
        oor = (a >= DEPTH);
        if (w) begin
            if (!oor) shadow[a] = size_mask(d, s);
            e = '{rd: 1'b0, val: last_rd, oor: oor};
        end else begin
            last_rd = oor ? 32'h0 : shadow[a];
            e = '{rd: 1'b1, val: last_rd, oor: oor};
        end
        sbq.push_back(e);
    endtask

    task automatic cycle(input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] s);
        @(negedge hclk);
        hreadyout = v;
        hwrite    = w;
        addr      = a;
        data      = d;
        hsize     = s;
        hburst    = 3'($urandom);
        chk("hready", {31'b0, hready}, {31'b0, busy == 0});
        if (v && busy == 0) begin
            accept(w, a, d, s);
            busy = 2;
        end else if (busy > 0) begin
            busy--;
        end
    endtask

    task automatic xfer(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] s);
        cycle(1'b1, w, a, d, s);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 3'd2);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 3'd2);
    endtask

    // Monitor: a completion is seen as hready returning high outside reset
    initial begin
        logic prev;
        logic done;
        exp_t e;
        prev = 1'b1;
        forever begin
            @(negedge hclk);
            if (!hresetn) begin
                prev = 1'b1;
            end else begin
                done = !prev && hready;
                e    = '{rd: 1'b0, val: 32'h0, oor: 1'b0};
                if (done) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_completion", 32'd1, 32'd0);
                    end else begin
                        e = sbq.pop_front();
                        chk(e.rd ? "read_data" : "read_data_hold",
                            read_data, e.val);
                    end
                end
`ifdef AHB_TOP_ERR_EN
                chk("herror", {31'b0, herror}, {31'b0, done && e.oor});
`endif
                prev = hready;
            end
        end
    end

    initial begin
        logic [31:0] a;
        hresetn   = 1'b0;
        hreadyout = 1'b0;
        hwrite    = 1'b0;
        addr      = '0;
        data      = '0;
        hburst    = '0;
        hsize     = 3'd2;
        model_reset();
        repeat (3) @(negedge hclk);
        chk("reset_read_data", read_data, 32'h0);
        chk("reset_hready", {31'b0, hready}, 32'd1);
        hresetn = 1'b1;

        xfer(1'b0, 32'd5, 32'h0, 3'd2);
        xfer(1'b1, 32'd3, 32'hA5A5_1234, 3'd2);
        xfer(1'b0, 32'd3, 32'h0, 3'd0);
        xfer(1'b1, 32'd7, 32'hFFFF_FFFF, 3'd0);
        xfer(1'b0, 32'd7, 32'h0, 3'd2);
        xfer(1'b1, 32'd7, 32'hFFFF_FFFF, 3'd1);
        xfer(1'b0, 32'd7, 32'h0, 3'd2);
        xfer(1'b1, 32'd9, 32'h1234_5678, 3'd3);
        xfer(1'b0, 32'd9, 32'h0, 3'd7);
        xfer(1'b1, 32'd40, 32'h1111_1111, 3'd2);
        xfer(1'b0, 32'd40, 32'h0, 3'd2);
        xfer(1'b0, 32'd8, 32'h0, 3'd2);
        xfer(1'b0, 32'd3, 32'h0, 3'd2);
        xfer(1'b0, 32'd31, 32'h0, 3'd2);
        xfer(1'b1, 32'd31, 32'hCAFE_F00D, 3'd2);
        xfer(1'b0, 32'd31, 32'h0, 3'd2);

        for (int i = 0; i < 100; i++) begin
            a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
            cycle(1'b1, 1'($urandom), a, $urandom, 3'($urandom));
        end
        for (int i = 0; i < 200; i++) begin
            a = 32'($urandom_range(0, DEPTH + 7));
            cycle(1'($urandom), 1'($urandom), a, $urandom, 3'($urandom));
        end
        for (int i = 0; i < DEPTH; i++) xfer(1'b0, 32'(i), 32'h0, 3'd2);

        cycle(1'b1, 1'b1, 32'd2, 32'hDEAD_BEEF, 3'd2);
        @(negedge hclk);
        #2;
        hresetn   = 1'b0;
        hreadyout = 1'b0;
        model_reset();
        repeat (2) @(negedge hclk);
        hresetn = 1'b1;
        chk("post_reset_hready", {31'b0, hready}, 32'd1);
        xfer(1'b0, 32'd2, 32'h0, 3'd2);
        xfer(1'b0, 32'd3, 32'h0, 3'd2);

        repeat (4) cycle(1'b0, 1'b0, 32'h0, 32'h0, 3'd2);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
